// File: rtl/imm_gen_pipe.sv
// Registered immediate generator for the decode stage.
// Extends raw immediates and merges latched PREFIX bits.
module imm_gen_pipe #(
  parameter int DATA_W  = 16,
  parameter int IMM_W   = 8,
  parameter int SHAMT_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        mode,
  input  logic [IMM_W-1:0]  imm_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ext_data,
  output logic              prefix_pending,
  output logic              err_pulse
);

  localparam int PW = DATA_W - IMM_W;

  localparam logic [2:0] M_SEXT  = 3'd0;
  localparam logic [2:0] M_ZEXT  = 3'd1;
  localparam logic [2:0] M_SHAMT = 3'd2;
  localparam logic [2:0] M_LUI   = 3'd3;
  localparam logic [2:0] M_PFX   = 3'd4;

  logic [PW-1:0]     prefix_reg;
  logic [PW-1:0]     pfx_nxt;
  logic [DATA_W-1:0] res;
  logic              acc;
  logic              is_sext;
  logic              is_zext;
  logic              is_shamt;
  logic              is_lui;
  logic              is_pfx;

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready && !flush;

  assign is_sext  = (mode == M_SEXT);
  assign is_zext  = (mode == M_ZEXT);
  assign is_shamt = (mode == M_SHAMT);
  assign is_lui   = (mode == M_LUI);
  assign is_pfx   = (mode == M_PFX);

  // Prefix field is the PW bits above the immediate.
  generate
    if (PW <= IMM_W) begin : g_pfx_narrow
      assign pfx_nxt = imm_in[PW-1:0];
    end else begin : g_pfx_wide
      assign pfx_nxt = {{(PW-IMM_W){1'b0}}, imm_in};
    end
  endgenerate

  always_comb begin
    res = '0;
    unique case (1'b1)
      is_sext, is_zext: begin
        if (prefix_pending)
          res = {prefix_reg, imm_in};
        else if (is_sext)
          res = {{PW{imm_in[IMM_W-1]}}, imm_in};
        else
          res = {{PW{1'b0}}, imm_in};
      end
      is_shamt:
        res = {{(DATA_W-SHAMT_W-1){imm_in[SHAMT_W]}},
               imm_in[SHAMT_W:0]};
      is_lui:
        res = {imm_in, {PW{1'b0}}};
      default:
        res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid      <= 1'b0;
      ext_data       <= '0;
      prefix_pending <= 1'b0;
      prefix_reg     <= '0;
      err_pulse      <= 1'b0;
    end else if (flush) begin
      out_valid      <= 1'b0;
      prefix_pending <= 1'b0;
      err_pulse      <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (acc) begin
        unique case (1'b1)
          is_sext, is_zext: begin
            out_valid      <= 1'b1;
            ext_data       <= res;
            prefix_pending <= 1'b0;
          end
          is_shamt, is_lui: begin
            out_valid      <= 1'b1;
            ext_data       <= res;
            prefix_pending <= 1'b0;
            // Prefix not consumable by these modes: flag orphan.
            err_pulse      <= prefix_pending;
          end
          is_pfx: begin
            prefix_reg     <= pfx_nxt;
            prefix_pending <= 1'b1;
          end
          default:
            err_pulse <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe.
// Each task drives one scenario and checks inline.
module tb_imm_gen_pipe;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  mode;
  logic [7:0]  imm_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] ext_data;
  logic        prefix_pending;
  logic        err_pulse;

  int checks;
  int errors;

  imm_gen_pipe #(.DATA_W(16), .IMM_W(8), .SHAMT_W(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mode           (mode),
    .imm_in         (imm_in),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .ext_data       (ext_data),
    .prefix_pending (prefix_pending),
    .err_pulse      (err_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    mode      = 3'd0;
    imm_in    = 8'h00;
    flush     = 1'b0;
    out_ready = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ov got %b want 0", out_valid);
    end
    checks++;
    if (ext_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_ext got %h want 0000", ext_data);
    end
    checks++;
    if (prefix_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_pp got %b want 0", prefix_pending);
    end
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got %b want 0", err_pulse);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy got %b want 1", in_ready);
    end
    #10 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_ext();
    in_valid = 1'b1;
    mode     = 3'd0;
    imm_in   = 8'hF5;
    tick();
    checks++;
    if (out_valid !== 1'b1 || ext_data !== 16'hFFF5) begin
      errors++;
      $display("FAIL sext got %b/%h want 1/fff5",
               out_valid, ext_data);
    end
    mode = 3'd1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || ext_data !== 16'h00F5) begin
      errors++;
      $display("FAIL zext got %b/%h want 1/00f5",
               out_valid, ext_data);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ext_drain got %b want 0", out_valid);
    end
  endtask

  task automatic test_shamt();
    in_valid = 1'b1;
    mode     = 3'd2;
    imm_in   = 8'h1D;
    tick();
    checks++;
    if (ext_data !== 16'hFFFD || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL shamt_neg got %h/%b want fffd/0",
               ext_data, err_pulse);
    end
    imm_in = 8'hE3;
    tick();
    checks++;
    if (ext_data !== 16'h0003) begin
      errors++;
      $display("FAIL shamt_pos got %h want 0003", ext_data);
    end
  endtask

  task automatic test_prefix();
    mode   = 3'd4;
    imm_in = 8'h12;
    tick();
    checks++;
    if (prefix_pending !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pfx_latch got %b/%b want 1/0",
               prefix_pending, out_valid);
    end
    mode   = 3'd0;
    imm_in = 8'hF4;
    tick();
    checks++;
    if (out_valid !== 1'b1 || ext_data !== 16'h12F4 ||
        prefix_pending !== 1'b0 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL pfx_use got %b/%h/%b/%b want 1/12f4/0/0",
               out_valid, ext_data, prefix_pending, err_pulse);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pfx_once got %b want 0", out_valid);
    end
  endtask

  task automatic test_orphan();
    in_valid = 1'b1;
    mode     = 3'd4;
    imm_in   = 8'hAB;
    tick();
    mode   = 3'd3;
    imm_in = 8'h3C;
    tick();
    checks++;
    if (ext_data !== 16'h3C00 || err_pulse !== 1'b1 ||
        prefix_pending !== 1'b0) begin
      errors++;
      $display("FAIL orphan got %h/%b/%b want 3c00/1/0",
               ext_data, err_pulse, prefix_pending);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL orphan_len got %b want 0", err_pulse);
    end
  endtask

  task automatic test_reserved();
    in_valid = 1'b1;
    mode     = 3'd4;
    imm_in   = 8'h77;
    tick();
    mode = 3'd6;
    tick();
    checks++;
    if (err_pulse !== 1'b1 || out_valid !== 1'b0 ||
        prefix_pending !== 1'b1) begin
      errors++;
      $display("FAIL rsvd got %b/%b/%b want 1/0/1",
               err_pulse, out_valid, prefix_pending);
    end
    mode   = 3'd1;
    imm_in = 8'h05;
    tick();
    checks++;
    if (ext_data !== 16'h7705 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL rsvd_keep got %h/%b want 7705/0",
               ext_data, err_pulse);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    mode      = 3'd0;
    imm_in    = 8'h01;
    tick();
    imm_in = 8'h02;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          ext_data !== 16'h0001) begin
        errors++;
        $display("FAIL stall_hold%0d got %b/%b/%h want 0/1/0001",
                 i, in_ready, out_valid, ext_data);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_rdy got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || ext_data !== 16'h0002) begin
      errors++;
      $display("FAIL stall_next got %b/%h want 1/0002",
               out_valid, ext_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_dup got %b want 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    mode     = 3'd4;
    imm_in   = 8'h55;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (prefix_pending !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_pfx got %b/%b want 0/0",
               prefix_pending, out_valid);
    end
    #2 reset_n = 1'b1;
    in_valid = 1'b1;
    mode     = 3'd0;
    imm_in   = 8'h07;
    tick();
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || ext_data !== 16'h0000) begin
      errors++;
      $display("FAIL arst_stall got %b/%h want 0/0000",
               out_valid, ext_data);
    end
    #2 reset_n = 1'b1;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    in_valid = 1'b1;
    mode     = 3'd0;
    imm_in   = 8'h33;
    tick();
    mode   = 3'd4;
    imm_in = 8'h99;
    tick();
    mode   = 3'd5;
    imm_in = 8'h09;
    flush  = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || prefix_pending !== 1'b0 ||
        err_pulse !== 1'b0 || ext_data !== 16'h0033) begin
      errors++;
      $display("FAIL flush got %b/%b/%b/%h want 0/0/0/0033",
               out_valid, prefix_pending, err_pulse, ext_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ext();
    test_shamt();
    test_prefix();
    test_orphan();
    test_reserved();
    test_stall();
    test_async_reset();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
